if_fetch_queue: RTL and testbench
=================================

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, instruction queue entries (power of 2, 2..16).
REQ-002 Parameter RESET_PC, default 32'hBFC00000, first fetch address after reset.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 address  output  32  fetch address (virtual, unmapped) to the AXI read adapter.
REQ-006 address_valid  output  1  fetch request valid.
REQ-007 address_read_ready  input  1  one-cycle pulse: adapter accepted the current request.
REQ-008 data_valid  input  1  returned instruction valid this cycle.
REQ-009 data  input  32  returned instruction word.
REQ-010 data_address  input  32  address of the returned word.
REQ-011 flush  input  1  one-cycle redirect request.
REQ-012 flush_pc  input  32  redirect target, sampled when flush=1.
REQ-013 inst_valid  output  1  queue head valid toward decode.
REQ-014 inst  output  32  queue head instruction.
REQ-015 inst_pc  output  32  queue head address.
REQ-016 inst_ready  input  1  decode consumes head when inst_valid and inst_ready.

Function
REQ-017 Registers: pc[31:0], outstanding (0..DEPTH), discard (0..DEPTH), count (0..DEPTH), rd_ptr, wr_ptr, redirect_pending, redirect_pc.
REQ-018 Invariant: count + outstanding <= DEPTH in every cycle; a response never finds the queue full.
REQ-019 address_valid = 1 when count + outstanding < DEPTH, or when a request is held per REQ-020; address = pc.
REQ-020 Once address_valid=1 it stays 1 with address unchanged until address_read_ready=1; no retraction, including on flush.
REQ-021 Accept (address_valid and address_read_ready): outstanding +1; pc <= pc+4 (mod 2^32), or redirect_pc if redirect_pending (then redirect_pending <= 0, discard +1).
REQ-022 Response (data_valid): outstanding -1; if discard>0 then discard -1 and the word is dropped, else {data, data_address} written at wr_ptr and count +1.
REQ-023 Pop (inst_valid and inst_ready): rd_ptr +1, count -1; inst_valid = (count != 0); inst/inst_pc = entry at rd_ptr.
REQ-024 Push and pop in the same cycle: count unchanged, both pointers advance.
REQ-025 Pointers wrap modulo DEPTH.
REQ-026 Flush, no request held: queue emptied (count <= 0, rd_ptr <= wr_ptr), pc <= flush_pc, discard <= outstanding - (data_valid ? 1 : 0) + (accept ? 1 : 0).
REQ-027 Flush while a request is held and not accepted in that cycle: queue emptied, discard <= outstanding - (data_valid ? 1 : 0), redirect_pending <= 1, redirect_pc <= flush_pc; held address remains on the bus.
REQ-028 Flush has priority over pop and push in the same cycle; a data_valid word in the flush cycle is dropped and not counted into discard.
REQ-029 A second flush while redirect_pending=1 overwrites redirect_pc; discard is recomputed per REQ-027.
REQ-030 data_valid with outstanding=0 is a protocol error and is ignored (no state change).
REQ-031 Request-to-inst_valid latency: response cycle +1 (registered queue write).

Reset
REQ-032 With reset=1 at a rising edge: pc <= RESET_PC; outstanding, discard, count, rd_ptr, wr_ptr, redirect_pending <= 0.
REQ-033 During reset, outputs are address_valid=0, inst_valid=0, inst=0, inst_pc=0, and address=RESET_PC.
REQ-034 Reset mid-transaction discards all in-flight state; after reset the first request is at RESET_PC.
REQ-035 After reset release, address_valid rises in the first cycle with address=32'hBFC00000.

Verification
REQ-036 Sequential fetch, adapter accepts each request in 1 cycle and returns data 2 cycles later, inst_ready=1 -> inst_pc sequence BFC00000, BFC00004, BFC00008, with no gaps beyond the adapter's latency.
REQ-037 Backpressure: inst_ready=0 -> exactly 4 words are queued, address_valid=0 while count + outstanding = 4, no overflow; inst_ready=1 resumes fetching in order.
REQ-038 Flush with 2 requests outstanding, flush_pc=80000100 -> both stale responses are dropped, and the first inst_pc is 80000100.
REQ-039 Flush while request BFC00010 is held unaccepted -> address stays BFC00010 until accepted, then the next request is 80000100, and the BFC00010 response is dropped.
REQ-040 Flush coincident with data_valid and inst_ready -> queue empty, that word is dropped, and discard = outstanding - 1.
REQ-041 Reset asserted with count=3 and outstanding=1 -> next cycle inst_valid=0 and address=BFC00000 with address_valid=1.

Source files
------------

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch request generator with a response queue toward decode.
// Requests are throttled so every outstanding response has a guaranteed queue slot.
module if_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] address,
    output logic        address_valid,
    input  logic        address_read_ready,
    input  logic        data_valid,
    input  logic [31:0] data,
    input  logic [31:0] data_address,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]   pc, redirect_pc;
    logic [CW-1:0] outstanding, discard, count;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          redirect_pending, held;
    logic [31:0]   mem_data [DEPTH];
    logic [31:0]   mem_pc [DEPTH];
    logic [CW:0]   used;
    logic          accept, resp, drop, push, pop;

    assign used          = {1'b0, count} + {1'b0, outstanding};
    assign address_valid = !reset && (held || used < DEPTH_W);
    assign address       = reset ? RESET_PC : pc;
    assign inst_valid    = !reset && count != '0;
    assign inst          = reset ? '0 : mem_data[rd_ptr];
    assign inst_pc       = reset ? '0 : mem_pc[rd_ptr];
    assign accept        = address_valid && address_read_ready;
    // Responses with nothing outstanding are protocol errors and are ignored.
    assign resp          = data_valid && outstanding != '0;
    assign drop          = resp && discard != '0;
    assign push          = resp && !drop && !flush;
    assign pop           = inst_valid && inst_ready && !flush;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= data;
            mem_pc[wr_ptr]   <= data_address;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc               <= RESET_PC;
            redirect_pc      <= RESET_PC;
            outstanding      <= '0;
            discard          <= '0;
            count            <= '0;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            redirect_pending <= 1'b0;
            held             <= 1'b0;
        end else begin
            held        <= address_valid && !address_read_ready;
            outstanding <= outstanding + CW'(accept) - CW'(resp);
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (flush) begin
                count   <= '0;
                rd_ptr  <= wr_ptr;
                discard <= outstanding - CW'(resp) + CW'(accept);
                // A request already on the bus cannot be retracted; retarget the one after it.
                if (address_valid && !address_read_ready) begin
                    redirect_pending <= 1'b1;
                    redirect_pc      <= flush_pc;
                end else begin
                    redirect_pending <= 1'b0;
                    pc               <= flush_pc;
                end
            end else begin
                count   <= count + CW'(push) - CW'(pop);
                discard <= discard - CW'(drop) + CW'(accept && redirect_pending);
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (accept) begin
                    pc               <= redirect_pending ? redirect_pc : pc + 32'd4;
                    redirect_pending <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed scenarios against a fixed-latency adapter model.
module tb_if_fetch_queue;
    logic        clk, reset;
    logic [31:0] address, data, data_address, flush_pc, inst, inst_pc;
    logic        address_valid, address_read_ready, data_valid, flush, inst_valid, inst_ready;

    if_fetch_queue dut (
        .clk(clk), .reset(reset), .address(address), .address_valid(address_valid),
        .address_read_ready(address_read_ready), .data_valid(data_valid), .data(data),
        .data_address(data_address), .flush(flush), .flush_pc(flush_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
    );

    typedef struct {
        logic [31:0] a;
        int          due;
    } pend_t;

    int          checks = 0, passed = 0, cyc = 0;
    logic        adapter_en;
    logic [31:0] stop_addr;
    logic [31:0] popped[$], accepts[$];
    pend_t       pend[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Adapter: accepts any valid request at once, returns ~addr two cycles after acceptance.
    task automatic drive();
        address_read_ready = adapter_en && address_valid && address != stop_addr;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            data_valid   = 1'b1;
            data         = ~pend[0].a;
            data_address = pend[0].a;
            pend.delete(0);
        end else begin
            data_valid = 1'b0;
        end
    endtask

    task automatic cycle();
        if (address_valid && address_read_ready) begin
            accepts.push_back(address);
            pend.push_back('{address, cyc + 2});
        end
        if (inst_valid && inst_ready && !flush)
            popped.push_back(inst_pc);
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic clear_model();
        pend.delete();
        accepts.delete();
        popped.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b0;
        inst_ready = 1'b0;
        adapter_en = 1'b1;
        stop_addr = 32'h1;
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        clear_model();
        drive();
    endtask

    function automatic logic [31:0] pop_at(int i);
        return (popped.size() > i) ? popped[i] : 32'hxxxxxxxx;
    endfunction

    function automatic int stale_count();
        int n = 0;
        foreach (popped[i]) if (popped[i][31:20] == 12'hBFC) n++;
        return n;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        adapter_en = 1'b1;
        stop_addr = 32'h1;
        cycle();
        cycle();
        checks++; if (address_valid !== 1'b0) $display("FAIL rst_av: got %b exp 0", address_valid); else passed++;
        checks++; if (inst_valid !== 1'b0) $display("FAIL rst_iv: got %b exp 0", inst_valid); else passed++;
        checks++; if (inst !== 32'h0) $display("FAIL rst_inst: got %h exp 0", inst); else passed++;
        checks++; if (inst_pc !== 32'h0) $display("FAIL rst_inst_pc: got %h exp 0", inst_pc); else passed++;
        checks++; if (address !== 32'hBFC00000) $display("FAIL rst_addr: got %h exp bfc00000", address); else passed++;
        reset = 1'b0;
        #1;
        checks++; if (address_valid !== 1'b1) $display("FAIL rel_av: got %b exp 1", address_valid); else passed++;
        checks++; if (address !== 32'hBFC00000) $display("FAIL rel_addr: got %h exp bfc00000", address); else passed++;
    endtask

    task automatic test_sequential();
        int bad = 0;
        do_reset();
        inst_ready = 1'b1;
        repeat (2) cycle();
        checks++; if (inst_valid !== 1'b0) $display("FAIL seq_early_iv: got %b exp 0", inst_valid); else passed++;
        cycle();
        checks++; if (inst_valid !== 1'b1) $display("FAIL seq_latency_iv: got %b exp 1", inst_valid); else passed++;
        checks++; if (inst_pc !== 32'hBFC00000) $display("FAIL seq_head_pc: got %h exp bfc00000", inst_pc); else passed++;
        checks++; if (inst !== 32'h403FFFFF) $display("FAIL seq_head_inst: got %h exp 403fffff", inst); else passed++;
        repeat (9) cycle();
        checks++; if (popped.size() < 9) $display("FAIL seq_throughput: got %0d pops exp 9", popped.size()); else passed++;
        checks++; if (pop_at(1) !== 32'hBFC00004) $display("FAIL seq_pc1: got %h exp bfc00004", pop_at(1)); else passed++;
        checks++; if (pop_at(2) !== 32'hBFC00008) $display("FAIL seq_pc2: got %h exp bfc00008", pop_at(2)); else passed++;
        foreach (popped[i]) if (popped[i] !== 32'hBFC00000 + 32'(4 * i)) bad++;
        checks++; if (bad != 0) $display("FAIL seq_order: got %0d out-of-order pops exp 0", bad); else passed++;
    endtask

    task automatic test_backpressure();
        int bad = 0;
        do_reset();
        repeat (10) cycle();
        checks++; if (accepts.size() != 4) $display("FAIL bp_accepts: got %0d exp 4", accepts.size()); else passed++;
        checks++; if (address_valid !== 1'b0) $display("FAIL bp_av: got %b exp 0", address_valid); else passed++;
        checks++; if (inst_pc !== 32'hBFC00000) $display("FAIL bp_head: got %h exp bfc00000", inst_pc); else passed++;
        repeat (5) cycle();
        checks++; if (accepts.size() != 4) $display("FAIL bp_overflow: got %0d exp 4", accepts.size()); else passed++;
        inst_ready = 1'b1;
        repeat (16) cycle();
        checks++; if (popped.size() < 8) $display("FAIL bp_resume: got %0d pops exp >=8", popped.size()); else passed++;
        foreach (popped[i]) if (popped[i] !== 32'hBFC00000 + 32'(4 * i)) bad++;
        checks++; if (bad != 0) $display("FAIL bp_order: got %0d out-of-order pops exp 0", bad); else passed++;
    endtask

    task automatic test_flush_outstanding();
        do_reset();
        inst_ready = 1'b1;
        repeat (2) cycle();
        flush_pc = 32'h80000100;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        popped.delete();
        checks++; if (address !== 32'h80000100) $display("FAIL fo_addr: got %h exp 80000100", address); else passed++;
        checks++; if (inst_valid !== 1'b0) $display("FAIL fo_empty: got %b exp 0", inst_valid); else passed++;
        repeat (10) cycle();
        checks++; if (pop_at(0) !== 32'h80000100) $display("FAIL fo_first: got %h exp 80000100", pop_at(0)); else passed++;
        checks++; if (pop_at(1) !== 32'h80000104) $display("FAIL fo_second: got %h exp 80000104", pop_at(1)); else passed++;
        checks++; if (stale_count() != 0) $display("FAIL fo_stale: got %0d stale pops exp 0", stale_count()); else passed++;
    endtask

    task automatic test_flush_held();
        int idx = -1;
        bit found = 0;
        do_reset();
        inst_ready = 1'b1;
        stop_addr = 32'hBFC00010;
        for (int i = 0; i < 20 && !found; i++) begin
            if (address_valid && address == 32'hBFC00010) found = 1;
            else cycle();
        end
        checks++; if (!found) $display("FAIL fh_reach: got no held request exp bfc00010"); else passed++;
        flush_pc = 32'h80000100;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        popped.delete();
        checks++; if (address !== 32'hBFC00010) $display("FAIL fh_hold_addr: got %h exp bfc00010", address); else passed++;
        repeat (3) cycle();
        checks++; if (address_valid !== 1'b1 || address !== 32'hBFC00010) $display("FAIL fh_still_held: got %b/%h exp 1/bfc00010", address_valid, address); else passed++;
        stop_addr = 32'h1;
        drive();
        repeat (12) cycle();
        foreach (accepts[i]) if (accepts[i] == 32'hBFC00010) idx = i;
        checks++; if (idx < 0 || idx + 1 >= accepts.size() || accepts[idx+1] !== 32'h80000100) $display("FAIL fh_next_req: got idx %0d exp 80000100 after bfc00010", idx); else passed++;
        checks++; if (pop_at(0) !== 32'h80000100) $display("FAIL fh_first: got %h exp 80000100", pop_at(0)); else passed++;
        checks++; if (stale_count() != 0) $display("FAIL fh_stale: got %0d stale pops exp 0", stale_count()); else passed++;
    endtask

    task automatic test_flush_data();
        bit found = 0;
        do_reset();
        inst_ready = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            if (data_valid && inst_valid) found = 1;
            else cycle();
        end
        checks++; if (!found) $display("FAIL fd_reach: got no coincident data/inst exp one"); else passed++;
        flush_pc = 32'h80000200;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        popped.delete();
        checks++; if (inst_valid !== 1'b0) $display("FAIL fd_empty: got %b exp 0", inst_valid); else passed++;
        repeat (12) cycle();
        checks++; if (pop_at(0) !== 32'h80000200) $display("FAIL fd_first: got %h exp 80000200", pop_at(0)); else passed++;
        checks++; if (pop_at(1) !== 32'h80000204) $display("FAIL fd_second: got %h exp 80000204", pop_at(1)); else passed++;
        checks++; if (stale_count() != 0) $display("FAIL fd_stale: got %0d stale pops exp 0", stale_count()); else passed++;
    endtask

    task automatic test_protocol_error();
        do_reset();
        adapter_en = 1'b0;
        drive();
        data_valid = 1'b1;
        data = 32'hDEADBEEF;
        data_address = 32'h12345678;
        cycle();
        checks++; if (inst_valid !== 1'b0) $display("FAIL pe_iv: got %b exp 0", inst_valid); else passed++;
        checks++; if (address_valid !== 1'b1 || address !== 32'hBFC00000) $display("FAIL pe_req: got %b/%h exp 1/bfc00000", address_valid, address); else passed++;
        adapter_en = 1'b1;
        inst_ready = 1'b1;
        drive();
        repeat (8) cycle();
        checks++; if (pop_at(0) !== 32'hBFC00000) $display("FAIL pe_recover: got %h exp bfc00000", pop_at(0)); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (5) cycle();
        checks++; if (inst_valid !== 1'b1) $display("FAIL rm_pre_iv: got %b exp 1", inst_valid); else passed++;
        reset = 1'b1;
        cycle();
        checks++; if (address_valid !== 1'b0 || inst_valid !== 1'b0) $display("FAIL rm_during: got av %b iv %b exp 0/0", address_valid, inst_valid); else passed++;
        reset = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0) $display("FAIL rm_iv: got %b exp 0", inst_valid); else passed++;
        checks++; if (address_valid !== 1'b1 || address !== 32'hBFC00000) $display("FAIL rm_req: got %b/%h exp 1/bfc00000", address_valid, address); else passed++;
        clear_model();
        drive();
        inst_ready = 1'b1;
        repeat (8) cycle();
        checks++; if (pop_at(0) !== 32'hBFC00000) $display("FAIL rm_first: got %h exp bfc00000", pop_at(0)); else passed++;
        checks++; if (pop_at(1) !== 32'hBFC00004) $display("FAIL rm_second: got %h exp bfc00004", pop_at(1)); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        address_read_ready = 1'b0;
        data_valid = 1'b0;
        data = '0;
        data_address = '0;
        flush = 1'b0;
        flush_pc = '0;
        inst_ready = 1'b0;
        adapter_en = 1'b0;
        stop_addr = 32'h1;
        test_reset();
        test_sequential();
        test_backpressure();
        test_flush_outstanding();
        test_flush_held();
        test_flush_data();
        test_protocol_error();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
